// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
// One request is outstanding at a time; the ack is a single-cycle pulse carrying the data.
interface fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) ();
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one imem read at a time and buffers
// returned words in a prefetch FIFO presented to decode; redirect flushes and restarts.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    fetch_unit_if.master       imem,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  pc_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

    logic [INSTR_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem   [DEPTH];

    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   count_nx;
    logic               has_room;

    // A word arriving during a redirect belongs to the old stream and is never stored.
    assign push     = imem.imem_ack && (state_q == S_WAIT) && !redirect;
    assign pop      = instr_valid && instr_ready;
    assign count_nx = count_q + CNT_W'(push) - CNT_W'(pop);
    assign has_room = (count_nx < CNT_W'(DEPTH));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        pc_d     = pc_q;
        count_d  = count_nx;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        if (redirect) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pc_d     = redirect_pc;
            // An unanswered request must be drained before the new address can go out.
            if (state_q != S_IDLE && !imem.imem_ack) begin
                state_d = S_FLUSH;
            end else begin
                state_d = S_WAIT;
                addr_d  = redirect_pc;
                pc_d    = redirect_pc + ADDR_W'(1);
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (has_room) begin
                        state_d = S_WAIT;
                        addr_d  = pc_q;
                        pc_d    = pc_q + ADDR_W'(1);
                    end
                end
                S_WAIT: begin
                    if (imem.imem_ack) begin
                        if (has_room) begin
                            addr_d = pc_q;
                            pc_d   = pc_q + ADDR_W'(1);
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_FLUSH: begin
                    if (imem.imem_ack) begin
                        state_d = S_WAIT;
                        addr_d  = pc_q;
                        pc_d    = pc_q + ADDR_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        req_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            addr_q   <= '0;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem.imem_rdata;
            pc_mem[wr_ptr_q]   <= addr_q;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign pc_out         = pc_q;
    assign instr_valid    = (count_q != '0);
    assign instr          = instr_valid ? data_mem[rd_ptr_q] : '0;
    assign instr_pc       = instr_valid ? pc_mem[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns {~addr, addr}, either acking in the same
// cycle as the request (auto) or under explicit step-by-step control (manual).
module tb_fetch_unit;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] pc_out;
    logic              auto_mem;
    logic              man_ack;

    int errors = 0;
    int checks = 0;

    fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) imem ();

    assign imem.imem_ack   = auto_mem ? imem.imem_req : man_ack;
    assign imem.imem_rdata = {~imem.imem_addr, imem.imem_addr};

    fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(4), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .imem        (imem),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc_out      (pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
        return 32'({~a, a});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n       = 1'b0;
        auto_mem    = 1'b1;
        man_ack     = 1'b0;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        step();
        step();

        // Reset values
        $display("reset: check outputs");
        chk("rst_req",   32'(imem.imem_req),  32'd0);
        chk("rst_addr",  32'(imem.imem_addr), 32'd0);
        chk("rst_pc",    32'(pc_out),         32'd0);
        chk("rst_valid", 32'(instr_valid),    32'd0);
        chk("rst_instr", 32'(instr),          32'd0);
        chk("rst_ipc",   32'(instr_pc),       32'd0);

        // Streaming, zero-wait memory, always-ready decode
        rst_n = 1'b1;
        step();
        $display("stream: first request addr=%0h req=%0b", imem.imem_addr, imem.imem_req);
        chk("s_req0",   32'(imem.imem_req),  32'd1);
        chk("s_addr0",  32'(imem.imem_addr), 32'd0);
        chk("s_valid0", 32'(instr_valid),    32'd0);
        for (int i = 1; i < 6; i++) begin
            step();
            $display("stream: addr=%0h instr_pc=%0h instr=%0h", imem.imem_addr, instr_pc, instr);
            chk("s_addr",  32'(imem.imem_addr), 32'(i));
            chk("s_valid", 32'(instr_valid),    32'd1);
            chk("s_ipc",   32'(instr_pc),       32'(i - 1));
            chk("s_instr", 32'(instr),          word_of(ADDR_W'(i - 1)));
        end

        // Queue fills with decode stalled
        instr_ready = 1'b0;
        do_reset();
        step(); step(); step(); step();
        $display("full: req=%0b pc_out=%0h head_pc=%0h", imem.imem_req, pc_out, instr_pc);
        chk("f_req",   32'(imem.imem_req), 32'd0);
        chk("f_pc",    32'(pc_out),        32'd4);
        chk("f_valid", 32'(instr_valid),   32'd1);
        chk("f_ipc",   32'(instr_pc),      32'd0);
        step();
        chk("f_req_hold", 32'(imem.imem_req), 32'd0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        $display("full: one pop -> req=%0b addr=%0h head_pc=%0h", imem.imem_req, imem.imem_addr, instr_pc);
        chk("f_req4",  32'(imem.imem_req),  32'd1);
        chk("f_addr4", 32'(imem.imem_addr), 32'd4);
        chk("f_ipc1",  32'(instr_pc),       32'd1);
        step();
        chk("f_req_off", 32'(imem.imem_req), 32'd0);
        chk("f_pc5",     32'(pc_out),        32'd5);

        // Redirect during an outstanding slow request enters FLUSH
        auto_mem    = 1'b0;
        instr_ready = 1'b1;
        do_reset();
        man_ack     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 8'h05;
        step();
        man_ack  = 1'b0;
        redirect = 1'b0;
        $display("flush: request addr=%0h", imem.imem_addr);
        chk("r_addr05",  32'(imem.imem_addr), 32'h05);
        chk("r_valid0",  32'(instr_valid),    32'd0);
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        step();
        redirect = 1'b0;
        $display("flush: held addr=%0h pc_out=%0h", imem.imem_addr, pc_out);
        chk("r_hold",   32'(imem.imem_addr), 32'h05);
        chk("r_pc40",   32'(pc_out),         32'h40);
        chk("r_req",    32'(imem.imem_req),  32'd1);
        step();
        chk("r_hold2",  32'(imem.imem_addr), 32'h05);
        man_ack = 1'b1;
        step();
        $display("flush: stale ack -> addr=%0h valid=%0b", imem.imem_addr, instr_valid);
        chk("r_addr40", 32'(imem.imem_addr), 32'h40);
        chk("r_drop",   32'(instr_valid),    32'd0);
        step();
        man_ack = 1'b0;
        $display("flush: first new head pc=%0h instr=%0h", instr_pc, instr);
        chk("r_valid",  32'(instr_valid), 32'd1);
        chk("r_ipc40",  32'(instr_pc),    32'h40);
        chk("r_ins40",  32'(instr),       word_of(8'h40));

        // Redirect coinciding with ack and pop
        auto_mem = 1'b1;
        do_reset();
        step(); step();
        chk("c_pre_ipc", 32'(instr_pc), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 8'h10;
        step();
        redirect = 1'b0;
        $display("coinc: addr=%0h valid=%0b pc_out=%0h", imem.imem_addr, instr_valid, pc_out);
        chk("c_addr10", 32'(imem.imem_addr), 32'h10);
        chk("c_valid0", 32'(instr_valid),    32'd0);
        chk("c_pc11",   32'(pc_out),         32'h11);
        step();
        $display("coinc: addr=%0h head_pc=%0h", imem.imem_addr, instr_pc);
        chk("c_addr11", 32'(imem.imem_addr), 32'h11);
        chk("c_ipc10",  32'(instr_pc),       32'h10);

        // Address wrap
        redirect    = 1'b1;
        redirect_pc = 8'hFE;
        step();
        redirect = 1'b0;
        $display("wrap: addr=%0h", imem.imem_addr);
        chk("w_fe", 32'(imem.imem_addr), 32'hFE);
        step();
        $display("wrap: addr=%0h head_pc=%0h", imem.imem_addr, instr_pc);
        chk("w_ff",     32'(imem.imem_addr), 32'hFF);
        chk("w_ipc_fe", 32'(instr_pc),       32'hFE);
        step();
        $display("wrap: addr=%0h head_pc=%0h", imem.imem_addr, instr_pc);
        chk("w_00",     32'(imem.imem_addr), 32'h00);
        chk("w_ipc_ff", 32'(instr_pc),       32'hFF);
        step();
        $display("wrap: addr=%0h head_pc=%0h", imem.imem_addr, instr_pc);
        chk("w_01",     32'(imem.imem_addr), 32'h01);
        chk("w_ipc_00", 32'(instr_pc),       32'h00);

        // Asynchronous reset mid-transaction
        auto_mem    = 1'b0;
        instr_ready = 1'b0;
        do_reset();
        man_ack = 1'b1;
        step(); step();
        man_ack = 1'b0;
        chk("a_pre_addr", 32'(imem.imem_addr), 32'd2);
        chk("a_pre_ipc",  32'(instr_pc),       32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        $display("async rst: req=%0b addr=%0h pc_out=%0h valid=%0b", imem.imem_req, imem.imem_addr, pc_out, instr_valid);
        chk("a_req",   32'(imem.imem_req),  32'd0);
        chk("a_addr",  32'(imem.imem_addr), 32'd0);
        chk("a_pc",    32'(pc_out),         32'd0);
        chk("a_valid", 32'(instr_valid),    32'd0);
        chk("a_instr", 32'(instr),          32'd0);
        chk("a_ipc",   32'(instr_pc),       32'd0);
        step();
        rst_n = 1'b1;
        step();
        $display("async rst: restart addr=%0h req=%0b", imem.imem_addr, imem.imem_req);
        chk("a_restart_req",  32'(imem.imem_req),  32'd1);
        chk("a_restart_addr", 32'(imem.imem_addr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
